// File: rtl/bg_scroll_renderer_if.sv
// Pixel-stream bundle between the VGA timing side, the external ROM/palette and the background renderer.
// The master side drives coordinates, controls, ROM data and palette colour; the slave side is the renderer.
interface bg_scroll_renderer_if #(
    parameter int LOG2_W = 9,
    parameter int LOG2_H = 9,
    parameter int IDX_W  = 2
);
    logic [9:0]               DrawX;
    logic [9:0]               DrawY;
    logic                     blank;
    logic                     auto_scroll;
    logic [LOG2_W-1:0]        scroll_x;
    logic [LOG2_H-1:0]        scroll_y;
    logic [3:0]               fade;
    logic [LOG2_W+LOG2_H-1:0] rom_addr;
    logic [IDX_W-1:0]         rom_q;
    logic [IDX_W-1:0]         pal_idx;
    logic [11:0]              pal_rgb;
    logic [3:0]               red;
    logic [3:0]               green;
    logic [3:0]               blue;
    logic                     frame_start;

    modport master (
        output DrawX, DrawY, blank, auto_scroll, scroll_x, scroll_y, fade, rom_q, pal_rgb,
        input  rom_addr, pal_idx, red, green, blue, frame_start
    );

    modport slave (
        input  DrawX, DrawY, blank, auto_scroll, scroll_x, scroll_y, fade, rom_q, pal_rgb,
        output rom_addr, pal_idx, red, green, blue, frame_start
    );
endinterface

// File: rtl/bg_scroll_renderer.sv
// Scaled, tiled, scrolled background: pixel coordinate -> ROM address -> palette -> faded RGB.
// Latency 2 + ROM_LATENCY cycles, fixed; free-running pixel stream, no backpressure.
module bg_scroll_renderer #(
    parameter int LOG2_W      = 9,
    parameter int LOG2_H      = 9,
    parameter int IDX_W       = 2,
    parameter int SCALE_SHIFT = 0,
    parameter int ROM_LATENCY = 1,
    parameter int V_ACTIVE    = 480
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    bg_scroll_renderer_if.slave bus
);

    logic [LOG2_W-1:0]  off_x;
    logic [LOG2_H-1:0]  off_y;
    logic [3:0]         fade_q;
    logic               boundary;
    logic [LOG2_W-1:0]  ix;
    logic [LOG2_H-1:0]  iy;
    // bit 0 travels with rom_addr, bit ROM_LATENCY lines up with rom_q
    logic [ROM_LATENCY:0] blank_pipe;
    logic [4:0]         gain;
    logic [7:0]         prod_r;
    logic [7:0]         prod_g;
    logic [7:0]         prod_b;

    assign boundary    = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_ACTIVE));
    assign bus.pal_idx = bus.rom_q;

    always_comb begin
        ix     = '0;
        iy     = '0;
        gain   = '0;
        prod_r = '0;
        prod_g = '0;
        prod_b = '0;
        // Truncation to the image width gives the wrap-around tiling.
        ix     = LOG2_W'(bus.DrawX >> SCALE_SHIFT) + off_x;
        iy     = LOG2_H'(bus.DrawY >> SCALE_SHIFT) + off_y;
        gain   = {1'b0, fade_q} + 5'd1;
        prod_r = {4'd0, bus.pal_rgb[11:8]} * {3'd0, gain};
        prod_g = {4'd0, bus.pal_rgb[7:4]}  * {3'd0, gain};
        prod_b = {4'd0, bus.pal_rgb[3:0]}  * {3'd0, gain};
    end

    // Scroll offsets and fade only move at the frame boundary so a frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            off_x           <= '0;
            off_y           <= '0;
            fade_q          <= 4'd15;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= boundary;
            if (boundary) begin
                fade_q <= bus.fade;
                if (bus.auto_scroll) begin
                    off_x <= off_x + bus.scroll_x;
                    off_y <= off_y + bus.scroll_y;
                end else begin
                    off_x <= bus.scroll_x;
                    off_y <= bus.scroll_y;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rom_addr <= '0;
            blank_pipe   <= '0;
        end else begin
            bus.rom_addr <= {iy, ix};
            blank_pipe   <= {blank_pipe[ROM_LATENCY-1:0], bus.blank};
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.red   <= '0;
            bus.green <= '0;
            bus.blue  <= '0;
        end else if (blank_pipe[ROM_LATENCY]) begin
            bus.red   <= prod_r[7:4];
            bus.green <= prod_g[7:4];
            bus.blue  <= prod_b[7:4];
        end else begin
            bus.red   <= '0;
            bus.green <= '0;
            bus.blue  <= '0;
        end
    end

endmodule
